// File: rtl/refill_pkg.sv
// Shared types for the cache refill sequencer.
// State encoding, way-id geometry and the free-way priority encoder.
package refill_pkg;

    localparam int WAY_ID_W = 4;
    localparam int SET_W    = 2;
    localparam int WAY_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        VICTIM,
        MEM_REQ,
        MEM_WAIT,
        FILL
    } state_e;

    typedef struct packed {
        logic             found;
        logic [WAY_W-1:0] way;
    } free_t;

    // Lowest-index way whose valid bit is clear.
    function automatic free_t first_free(input logic [3:0] valid4);
        free_t r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!valid4[i]) begin
                r.found = 1'b1;
                r.way   = WAY_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/refill_ctrl_if.sv
// Refill controller bus bundle: miss port, LRU port, memory port, array port.
// master = refill controller, slave = surrounding cache / memory.
interface refill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              flush;

    logic              repl_wr_en;
    logic              repl_full;
    logic [3:0]        repl_way_id;
    logic [15:0]       repl_valid;
    logic [4:0]        repl_way1;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;

    logic              arr_we;
    logic [3:0]        arr_way_id;
    logic [LINE_W-1:0] arr_data;

    logic              refill_done;
    logic              refill_err;

    modport master (
        input  miss_valid, miss_addr, flush,
        output miss_ready,
        output repl_wr_en, repl_full, repl_way_id, repl_valid,
        input  repl_way1,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output arr_we, arr_way_id, arr_data,
        output refill_done, refill_err
    );

    modport slave (
        output miss_valid, miss_addr, flush,
        input  miss_ready,
        input  repl_wr_en, repl_full, repl_way_id, repl_valid,
        output repl_way1,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  arr_we, arr_way_id, arr_data,
        input  refill_done, refill_err
    );

endinterface

// File: rtl/refill_ctrl.sv
// Cache-miss refill sequencer for the 4-set x 4-way cache.
// Allocates a way (free or LRU victim), fetches one line, writes the array.
module refill_ctrl
    import refill_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    refill_ctrl_if.master bus
);

    localparam int NV = NUM_SETS * NUM_WAYS;

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-5:0]   addr_q;
    logic [WAY_ID_W-1:0] tgt_q;
    logic [NV-1:0]       valid_q;
    logic [7:0]          timer_q;
    logic                flush_q;
    logic [LINE_W-1:0]   data_q;

    logic [SET_W-1:0]    set_w;
    free_t               free;
    logic [WAY_ID_W-1:0] vic_id;
    logic                vic_bad;
    logic                accept;
    logic                tmo;
    logic                unused_lo;

    assign set_w   = addr_q[SET_W-1:0];
    assign free    = first_free(valid_q[{set_w, 2'b00} +: NUM_WAYS]);
    assign vic_id  = bus.repl_way1[4:1];
    assign vic_bad = vic_id[3:2] != set_w;
    assign accept  = bus.miss_valid && bus.miss_ready;
    assign tmo     = timer_q == 8'(TIMEOUT);

    assign unused_lo = ^{bus.miss_addr[3:0], bus.repl_way1[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ALLOC;
            end
            ALLOC: begin
                state_d = free.found ? MEM_REQ : VICTIM;
            end
            VICTIM: begin
                state_d = vic_bad ? IDLE : MEM_REQ;
            end
            MEM_REQ: begin
                if (bus.mem_req_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.mem_rsp_valid) state_d = FILL;
                else if (tmo)          state_d = IDLE;
            end
            FILL: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.miss_ready    = 1'b0;
        bus.repl_wr_en    = 1'b0;
        bus.repl_full     = 1'b0;
        bus.repl_way_id   = '0;
        bus.mem_req_valid = 1'b0;
        bus.arr_we        = 1'b0;
        bus.arr_way_id    = '0;
        bus.refill_done   = 1'b0;
        bus.refill_err    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.miss_ready = !flush_q;
            end
            ALLOC: begin
                if (!free.found) begin
                    bus.repl_full   = 1'b1;
                    bus.repl_way_id = {set_w, 2'b00};
                end
            end
            VICTIM: begin
                bus.refill_err = vic_bad;
            end
            MEM_REQ: begin
                bus.mem_req_valid = 1'b1;
            end
            MEM_WAIT: begin
                bus.refill_err = !bus.mem_rsp_valid && tmo;
            end
            FILL: begin
                bus.arr_we      = 1'b1;
                bus.arr_way_id  = tgt_q;
                bus.repl_wr_en  = 1'b1;
                bus.repl_way_id = tgt_q;
                bus.refill_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.repl_valid   = valid_q;
    assign bus.mem_req_addr = {addr_q, 4'b0000};
    assign bus.arr_data     = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            tgt_q   <= '0;
            valid_q <= '0;
            timer_q <= '0;
            flush_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // A flush arriving mid-refill waits until the line is in.
            if (state_q != IDLE && bus.flush) flush_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) addr_q <= bus.miss_addr[ADDR_W-1:4];
                    if (flush_q || bus.flush) begin
                        valid_q <= '0;
                        flush_q <= 1'b0;
                    end
                end
                ALLOC: begin
                    if (free.found) tgt_q <= {set_w, free.way};
                end
                VICTIM: begin
                    if (!vic_bad) begin
                        tgt_q           <= vic_id;
                        valid_q[vic_id] <= 1'b0;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_req_ready) timer_q <= '0;
                end
                MEM_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    if (bus.mem_rsp_valid) data_q <= bus.mem_rsp_data;
                end
                FILL: begin
                    valid_q[tgt_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_refill_ctrl.sv
// Directed bench for refill_ctrl: vector table of refills plus
// hand sequences for async reset and flush-while-busy.
module tb_refill_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    refill_ctrl_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    refill_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0]  addr;
        int           stall;
        int           dly;
        logic [4:0]   victim;
        logic         noise;
        logic [127:0] data;
        logic         done;
        logic         err;
        int           lat;
        logic [3:0]   way;
        int           full;
        logic         vbit;
        int           flush_at;
    } vec_t;

    typedef struct {
        logic         done;
        logic         err;
        int           lat;
        int           req_cycles;
        logic [31:0]  req_addr;
        logic         unstable;
        logic [15:0]  req_vec;
        int           full_cnt;
        logic [3:0]   full_id;
        int           we_cnt;
        logic [3:0]   arr_id;
        logic [127:0] arr_data;
        int           wr_cnt;
        logic [3:0]   wr_id;
    } res_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input int stall,
                                input int dly, input logic [4:0] victim,
                                input logic noise, input logic done,
                                input int lat, input logic [3:0] way,
                                input int full, input logic vbit);
        vec_t v;
        v.addr     = addr;
        v.stall    = stall;
        v.dly      = dly;
        v.victim   = victim;
        v.noise    = noise;
        v.data     = {4{addr ^ 32'hA5C3_0F1E}};
        v.done     = done;
        v.err      = !done;
        v.lat      = lat;
        v.way      = way;
        v.full     = full;
        v.vbit     = vbit;
        v.flush_at = -1;
        return v;
    endfunction

    task automatic quiet();
        bus.miss_valid    = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    task automatic run_miss(input vec_t v, output res_t r);
        logic in_wait;
        int   widx;
        r = '{default: '0};
        in_wait = 1'b0;
        widx = 0;
        @(negedge clk);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = v.addr;
        bus.repl_way1  = v.victim;
        #1;
        chk("miss_ready", bus.miss_ready, 1'b1);
        @(posedge clk);
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            bus.miss_valid = 1'b0;
            bus.flush = in_wait && (widx == v.flush_at);
            if (in_wait) begin
                bus.mem_rsp_valid = (v.dly >= 0) && (widx >= v.dly);
                bus.mem_rsp_data  = v.data;
                widx++;
            end else begin
                bus.mem_rsp_valid = v.noise;
                bus.mem_rsp_data  = ~v.data;
            end
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                r.req_cycles++;
                bus.mem_req_ready = r.req_cycles > v.stall;
                if (r.req_cycles == 1) begin
                    r.req_addr = bus.mem_req_addr;
                    r.req_vec  = bus.repl_valid;
                end else if (bus.mem_req_addr != r.req_addr) begin
                    r.unstable = 1'b1;
                end
            end
            #1;
            if (bus.repl_full) begin
                r.full_cnt++;
                r.full_id = bus.repl_way_id;
            end
            if (bus.arr_we) begin
                r.we_cnt++;
                r.arr_id   = bus.arr_way_id;
                r.arr_data = bus.arr_data;
            end
            if (bus.repl_wr_en) begin
                r.wr_cnt++;
                r.wr_id = bus.repl_way_id;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) in_wait = 1'b1;
            if (bus.refill_done || bus.refill_err) begin
                r.done = bus.refill_done;
                r.err  = bus.refill_err;
                r.lat  = cyc;
                break;
            end
        end
        quiet();
    endtask

    task automatic chk_reset_outs(input string p);
        chk({p, "_memv"}, bus.mem_req_valid, 1'b0);
        chk({p, "_mema"}, bus.mem_req_addr, 32'h0);
        chk({p, "_vld"}, bus.repl_valid, 16'h0);
        chk({p, "_we"}, bus.arr_we, 1'b0);
        chk({p, "_wr"}, bus.repl_wr_en, 1'b0);
        chk({p, "_full"}, bus.repl_full, 1'b0);
        chk({p, "_done"}, bus.refill_done, 1'b0);
        chk({p, "_err"}, bus.refill_err, 1'b0);
        chk({p, "_data"}, bus.arr_data, 128'h0);
    endtask

    vec_t tbl[9];
    vec_t fv;
    res_t r;
    logic [15:0] vlast;

    initial begin
        quiet();
        bus.miss_addr = '0;
        bus.repl_way1 = '0;

        tbl[0] = mk(32'h10, 0,  0, 5'h00, 0, 1, 4,   4'h4, 0, 1);
        tbl[1] = mk(32'h20, 0,  0, 5'h00, 0, 1, 4,   4'h8, 0, 1);
        tbl[2] = mk(32'h24, 2,  0, 5'h00, 0, 1, 6,   4'h9, 0, 1);
        tbl[3] = mk(32'h2C, 0,  2, 5'h00, 0, 1, 6,   4'hA, 0, 1);
        tbl[4] = mk(32'hE8, 0,  0, 5'h00, 1, 1, 4,   4'hB, 0, 1);
        tbl[5] = mk(32'h28, 0,  0, 5'h12, 0, 1, 5,   4'h9, 1, 1);
        tbl[6] = mk(32'h30, 10, 0, 5'h00, 0, 1, 14,  4'hC, 0, 1);
        tbl[7] = mk(32'h34, 0, -1, 5'h00, 0, 0, 258, 4'hD, 0, 0);
        tbl[8] = mk(32'h2C, 0,  0, 5'h0B, 0, 0, 2,   4'h9, 1, 1);

        #1;
        chk_reset_outs("rst0");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_ready", bus.miss_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            string p;
            p = $sformatf("v%0d", i);
            run_miss(tbl[i], r);
            chk({p, "_done"}, r.done, tbl[i].done);
            chk({p, "_err"}, r.err, tbl[i].err);
            chk({p, "_lat"}, r.lat, tbl[i].lat);
            chk({p, "_full"}, r.full_cnt, tbl[i].full);
            chk({p, "_we"}, r.we_cnt, tbl[i].done ? 1 : 0);
            chk({p, "_wr"}, r.wr_cnt, tbl[i].done ? 1 : 0);
            if (tbl[i].full > 0)
                chk({p, "_fid"}, r.full_id, {tbl[i].addr[5:4], 2'b00});
            if (tbl[i].done) begin
                chk({p, "_aid"}, r.arr_id, tbl[i].way);
                chk({p, "_wid"}, r.wr_id, tbl[i].way);
                chk({p, "_adat"}, r.arr_data, tbl[i].data);
            end
            if (tbl[i].done || tbl[i].dly < 0) begin
                chk({p, "_radr"}, r.req_addr,
                    {tbl[i].addr[31:4], 4'h0});
                chk({p, "_rcyc"}, r.req_cycles, tbl[i].stall + 1);
                chk({p, "_stab"}, r.unstable, 1'b0);
                chk({p, "_rvec"}, r.req_vec[tbl[i].way], 1'b0);
            end
            @(negedge clk);
            #1;
            chk({p, "_vbit"}, bus.repl_valid[tbl[i].way], tbl[i].vbit);
        end
        vlast = bus.repl_valid;
        chk("vec_after_tbl", vlast, 16'h1F10);

        // Async reset while the memory request is stalled.
        @(negedge clk);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h04;
        @(posedge clk);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                bus.miss_valid = 1'b0;
                #1;
                seen = bus.mem_req_valid;
            end
            chk("rst_reach_req", seen, 1'b1);
        end
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst1");
        repeat (2) @(negedge clk);
        #1;
        chk("rst1_hold_memv", bus.mem_req_valid, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst1_ready", bus.miss_ready, 1'b1);
        chk("rst1_memv", bus.mem_req_valid, 1'b0);

        // Flush during MEM_WAIT: line lands, then everything clears.
        fv = mk(32'h00, 0, 2, 5'h00, 0, 1, 6, 4'h0, 0, 1);
        fv.flush_at = 1;
        run_miss(fv, r);
        chk("fl_done", r.done, 1'b1);
        chk("fl_lat", r.lat, 6);
        chk("fl_aid", r.arr_id, 4'h0);
        @(negedge clk);
        #1;
        chk("fl_ready_lo", bus.miss_ready, 1'b0);
        chk("fl_vec_set", bus.repl_valid, 16'h0001);
        @(negedge clk);
        #1;
        chk("fl_vec_clr", bus.repl_valid, 16'h0000);
        chk("fl_ready_hi", bus.miss_ready, 1'b1);

        // Flush pulse in IDLE clears the next cycle.
        run_miss(mk(32'h10, 0, 0, 5'h00, 0, 1, 4, 4'h4, 0, 1), r);
        chk("fi_done", r.done, 1'b1);
        @(negedge clk);
        #1;
        chk("fi_vec_set", bus.repl_valid, 16'h0010);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("fi_vec_clr", bus.repl_valid, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
